// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sequencer/averager.
// - ADC_BITS      : converter result width.
// - estado_prom_t : averager FSM states.
// - acc_ancho()   : accumulator width needed to sum 2^log2_n full-scale samples.
package adc_pkg;

  localparam int unsigned ADC_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    DISPARO,
    BAJA,
    ALTA,
    CAPTURA,
    SALIDA,
    ESPERA
  } estado_prom_t;

  function automatic int unsigned acc_ancho(input int unsigned log2_n);
    return ADC_BITS + log2_n;
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset (both flops clear to 0)
//   d     - asynchronous input
//   q     - synchronised output, 2 clk cycles of latency
module sincronizador_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/adc_promediador.sv
// Sequencer and averager for the 8-bit SAR converter. Issues periodic start-of-
// conversion pulses, waits for end-of-conversion, captures each result and
// emits the mean of 2^LOG2_N consecutive samples.
// Ports:
//   clk         - system clock
//   rst_n       - asynchronous active-low reset
//   enable      - 1 = continuous acquisition, 0 = stop and flush
//   sc          - start conversion (registered)
//   eoc         - end of conversion (asynchronous to clk)
//   resultado   - converter result, stable while synchronised eoc is high
//   muestra     - last raw captured sample
//   dato        - averaged value
//   dato_valido - one-cycle pulse, dato updated this cycle
//   error_to    - sticky wait-state timeout flag
module adc_promediador
  import adc_pkg::*;
#(
  parameter int unsigned LOG2_N   = 3,
  parameter int unsigned PERIODO  = 1000,
  parameter int unsigned SC_ANCHO = 4,
  parameter int unsigned TIMEOUT  = 4095
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  output logic                sc,
  input  logic                eoc,
  input  logic [ADC_BITS-1:0] resultado,
  output logic [ADC_BITS-1:0] muestra,
  output logic [ADC_BITS-1:0] dato,
  output logic                dato_valido,
  output logic                error_to
);

  localparam int unsigned ACC_W = acc_ancho(LOG2_N);
  localparam int unsigned CNT_W = LOG2_N + 1;
  localparam int unsigned PER_W = $clog2(PERIODO) + 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT) + 1;

  localparam logic [CNT_W-1:0] N_MUESTRAS = CNT_W'(2 ** LOG2_N);
  localparam logic [PER_W-1:0] PER_FIN    = PER_W'(PERIODO - 1);
  localparam logic [PER_W-1:0] SC_FIN     = PER_W'(SC_ANCHO - 1);
  localparam logic [TO_W-1:0]  TO_FIN     = TO_W'(TIMEOUT - 1);

  estado_prom_t          estado_q, estado_d;
  logic [PER_W-1:0]      per_q, per_d;
  logic [TO_W-1:0]       to_q, to_d;
  logic [ACC_W-1:0]      acc_q, acc_d, acc_sum;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_sum;
  logic [ADC_BITS-1:0]   muestra_q, muestra_d;
  logic [ADC_BITS-1:0]   dato_q, dato_d;
  logic                  dv_q, dv_d;
  logic                  err_q, err_d;
  logic                  sc_q, sc_d;
  logic                  en_q;
  logic                  eoc_s;

  sincronizador_2ff u_sync_eoc (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (eoc),
    .q     (eoc_s)
  );

  assign acc_sum = acc_q + ACC_W'(resultado);
  assign cnt_sum = cnt_q + CNT_W'(1);

  always_comb begin
    estado_d  = estado_q;
    per_d     = per_q;
    to_d      = '0;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    muestra_d = muestra_q;
    dato_d    = dato_q;
    dv_d      = 1'b0;
    err_d     = err_q;

    if (!enable) begin
      estado_d = IDLE;
      acc_d    = '0;
      cnt_d    = '0;
      per_d    = '0;
    end else begin
      unique case (estado_q)
        IDLE: begin
          // Only a fresh rising edge of enable starts a run.
          if (!en_q) begin
            err_d    = 1'b0;
            estado_d = DISPARO;
          end
        end
        DISPARO: begin
          if (per_q >= SC_FIN) estado_d = BAJA;
        end
        BAJA: begin
          // A stale high eoc_s must first drop before a result is trusted.
          if (!eoc_s) begin
            estado_d = ALTA;
          end else if (to_q == TO_FIN) begin
            err_d    = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
            estado_d = ESPERA;
          end
        end
        ALTA: begin
          if (eoc_s) begin
            estado_d = CAPTURA;
          end else if (to_q == TO_FIN) begin
            err_d    = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
            estado_d = ESPERA;
          end
        end
        CAPTURA: begin
          muestra_d = resultado;
          acc_d     = acc_sum;
          cnt_d     = cnt_sum;
          if (cnt_sum == N_MUESTRAS) begin
            // Output registers load here so they are visible during SALIDA.
            dato_d   = ADC_BITS'(acc_sum >> LOG2_N);
            dv_d     = 1'b1;
            estado_d = SALIDA;
          end else begin
            estado_d = ESPERA;
          end
        end
        SALIDA: begin
          acc_d    = '0;
          cnt_d    = '0;
          estado_d = ESPERA;
        end
        ESPERA: begin
          if (per_q >= PER_FIN) estado_d = DISPARO;
        end
        default: estado_d = IDLE;
      endcase

      // Period timer restarts on DISPARO entry and saturates otherwise.
      if (estado_d == DISPARO && estado_q != DISPARO) begin
        per_d = '0;
      end else if (per_q != '1) begin
        per_d = per_q + PER_W'(1);
      end

      // Wait-state timer counts cycles spent in the current BAJA/ALTA visit.
      if ((estado_d == BAJA || estado_d == ALTA) && estado_d == estado_q) begin
        to_d = to_q + TO_W'(1);
      end
    end

    sc_d = enable && (estado_q == DISPARO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= IDLE;
      per_q     <= '0;
      to_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      muestra_q <= '0;
      dato_q    <= '0;
      dv_q      <= 1'b0;
      err_q     <= 1'b0;
      sc_q      <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      per_q     <= per_d;
      to_q      <= to_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      muestra_q <= muestra_d;
      dato_q    <= dato_d;
      dv_q      <= dv_d;
      err_q     <= err_d;
      sc_q      <= sc_d;
      en_q      <= enable;
    end
  end

  assign sc          = sc_q;
  assign muestra     = muestra_q;
  assign dato        = dato_q;
  assign dato_valido = dv_q;
  assign error_to    = err_q;

endmodule

// File: tb/tb_adc_promediador.sv
// Bench for adc_promediador with a behavioural SAR converter model.
module tb_adc_promediador;

  localparam int unsigned LOG2_N   = 2;
  localparam int unsigned PERIODO  = 50;
  localparam int unsigned SC_ANCHO = 4;
  localparam int unsigned TIMEOUT  = 300;
  localparam int          N        = 1 << LOG2_N;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       sc;
  logic       eoc = 1'b1;
  logic [7:0] resultado = 8'd0;
  logic [7:0] muestra;
  logic [7:0] dato;
  logic       dato_valido;
  logic       error_to;

  int n_checks = 0;
  int n_fail   = 0;

  adc_promediador #(
    .LOG2_N   (LOG2_N),
    .PERIODO  (PERIODO),
    .SC_ANCHO (SC_ANCHO),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .sc          (sc),
    .eoc         (eoc),
    .resultado   (resultado),
    .muestra     (muestra),
    .dato        (dato),
    .dato_valido (dato_valido),
    .error_to    (error_to)
  );

  always #5 clk = ~clk;

  // Converter model: eoc drops on each sc rising edge, rises conv_delay cycles later
  // with the next queued sample. When stuck, it ignores sc and leaves eoc high.
  logic [7:0] samples[$];
  int  conv_delay = 20;
  bit  stuck = 1'b0;
  bit  busy = 1'b0;
  int  busy_cnt = 0;
  logic sc_prev = 1'b0;
  int  fed_n = 0;
  int  dv_n = 0;
  int  cyc = 0;
  int  last_sc_rise = -1;
  int  last_eoc_rise = -1;
  int  sc_gap_min = 1000000;
  int  sc_gap_max = 0;
  int  eoc_sc_max = 0;

  always @(negedge clk) begin
    cyc     <= cyc + 1;
    sc_prev <= sc;
    if (dato_valido) dv_n <= dv_n + 1;
    if (sc && !sc_prev) begin
      if (last_sc_rise >= 0) begin
        if (cyc - last_sc_rise < sc_gap_min) sc_gap_min <= cyc - last_sc_rise;
        if (cyc - last_sc_rise > sc_gap_max) sc_gap_max <= cyc - last_sc_rise;
      end
      if (last_eoc_rise >= 0 && cyc - last_eoc_rise > eoc_sc_max)
        eoc_sc_max <= cyc - last_eoc_rise;
      last_sc_rise <= cyc;
      if (!stuck) begin
        eoc      <= 1'b0;
        busy     <= 1'b1;
        busy_cnt <= 1;
      end
    end else if (busy) begin
      if (busy_cnt >= conv_delay) begin
        eoc           <= 1'b1;
        busy          <= 1'b0;
        fed_n         <= fed_n + 1;
        last_eoc_rise <= cyc;
        if (samples.size() > 0) resultado <= samples.pop_front();
        else resultado <= 8'($urandom_range(0, 255));
      end else begin
        busy_cnt <= busy_cnt + 1;
      end
    end
  end

  function automatic int mean_of(input int v[N]);
    int s = 0;
    for (int i = 0; i < N; i++) s += v[i];
    return s / N;
  endfunction

  task automatic restart();
    enable = 1'b0;
    repeat (3) @(posedge clk);
    for (int k = 0; k < 300 && busy; k++) @(posedge clk);
    #1;
    samples.delete();
    sc_gap_min    = 1000000;
    sc_gap_max    = 0;
    eoc_sc_max    = 0;
    last_sc_rise  = -1;
    last_eoc_rise = -1;
    enable = 1'b1;
  endtask

  task automatic wait_dv(input int bound, output bit got);
    got = 1'b0;
    for (int k = 0; k < bound && !got; k++) begin
      @(posedge clk);
      #1;
      if (dato_valido) got = 1'b1;
    end
  endtask

  task automatic wait_fed(input int target, input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < bound && !ok; k++) begin
      @(posedge clk);
      #1;
      if (fed_n >= target) ok = 1'b1;
    end
  endtask

  task automatic wait_sc(input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < bound && !ok; k++) begin
      @(posedge clk);
      #1;
      if (sc) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (sc !== 1'b0) begin n_fail++; $display("FAIL reset_sc: got %b want 0", sc); end
    n_checks++; if (muestra !== 8'd0) begin n_fail++; $display("FAIL reset_muestra: got %0d want 0", muestra); end
    n_checks++; if (dato !== 8'd0) begin n_fail++; $display("FAIL reset_dato: got %0d want 0", dato); end
    n_checks++; if (dato_valido !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b want 0", dato_valido); end
    n_checks++; if (error_to !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", error_to); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_average();
    int v[N] = '{10, 20, 30, 41};
    int exp = mean_of(v);
    bit got;
    restart();
    for (int i = 0; i < N; i++) samples.push_back(8'(v[i]));
    wait_dv(N * PERIODO + 100, got);
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL avg_dv: got %b want 1", got); end
    n_checks++; if (dato !== 8'(exp)) begin n_fail++; $display("FAIL avg_dato: got %0d want %0d", dato, exp); end
    n_checks++; if (muestra !== 8'd41) begin n_fail++; $display("FAIL avg_muestra: got %0d want 41", muestra); end
    @(posedge clk); #1;
    n_checks++; if (dato_valido !== 1'b0) begin n_fail++; $display("FAIL avg_pulse: got %b want 0", dato_valido); end
    n_checks++; if (error_to !== 1'b0) begin n_fail++; $display("FAIL avg_err: got %b want 0", error_to); end
  endtask

  task automatic test_extremes();
    bit got;
    restart();
    for (int i = 0; i < N; i++) samples.push_back(8'd255);
    for (int i = 0; i < N; i++) samples.push_back(8'd0);
    wait_dv(N * PERIODO + 100, got);
    n_checks++; if (got !== 1'b1 || dato !== 8'd255) begin n_fail++; $display("FAIL max_dato: got %0d (dv %b) want 255", dato, got); end
    wait_dv(N * PERIODO + 100, got);
    n_checks++; if (got !== 1'b1 || dato !== 8'd0) begin n_fail++; $display("FAIL zero_dato: got %0d (dv %b) want 0", dato, got); end
    n_checks++; if (sc_gap_min !== PERIODO || sc_gap_max !== PERIODO) begin
      n_fail++; $display("FAIL sc_period: got min %0d max %0d want %0d", sc_gap_min, sc_gap_max, PERIODO);
    end
  endtask

  task automatic test_random();
    bit got;
    int v[N];
    restart();
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < N; i++) begin
        v[i] = int'($urandom_range(0, 255));
        samples.push_back(8'(v[i]));
      end
      wait_dv(N * PERIODO + 100, got);
      n_checks++; if (got !== 1'b1 || dato !== 8'(mean_of(v))) begin
        n_fail++; $display("FAIL rand_dato[%0d]: got %0d (dv %b) want %0d", g, dato, got, mean_of(v));
      end
      n_checks++; if (muestra !== 8'(v[N-1])) begin
        n_fail++; $display("FAIL rand_muestra[%0d]: got %0d want %0d", g, muestra, v[N-1]);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok, got;
    int f0, dv0;
    restart();
    f0 = fed_n;
    samples.push_back(8'd200);
    samples.push_back(8'd200);
    wait_fed(f0 + 2, 3 * PERIODO, ok);
    stuck = 1'b1;
    dv0 = dv_n;
    ok = 1'b0;
    for (int k = 0; k < TIMEOUT + 3 * PERIODO && !ok; k++) begin
      @(posedge clk); #1;
      if (error_to) ok = 1'b1;
    end
    stuck = 1'b0;
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b want 1", error_to); end
    n_checks++; if (dv_n !== dv0) begin n_fail++; $display("FAIL to_no_dv: got %0d pulses want 0", dv_n - dv0); end
    for (int i = 0; i < N; i++) samples.push_back(8'd100);
    wait_dv(N * PERIODO + 100, got);
    n_checks++; if (got !== 1'b1 || dato !== 8'd100) begin n_fail++; $display("FAIL to_discard: got %0d (dv %b) want 100", dato, got); end
    n_checks++; if (error_to !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", error_to); end
    enable = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (error_to !== 1'b1) begin n_fail++; $display("FAIL to_hold_idle: got %b want 1", error_to); end
    enable = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_checks++; if (error_to !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b want 0", error_to); end
  endtask

  task automatic test_enable_drop();
    bit ok, got;
    int f0, dv0;
    logic [7:0] dato0;
    restart();
    f0 = fed_n;
    samples.push_back(8'd50);
    samples.push_back(8'd60);
    samples.push_back(8'd70);
    samples.push_back(8'd70);
    wait_fed(f0 + 2, 3 * PERIODO, ok);
    wait_sc(2 * PERIODO, ok);
    repeat (12) @(posedge clk);
    #1;
    dv0   = dv_n;
    dato0 = dato;
    enable = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (sc !== 1'b0) begin n_fail++; $display("FAIL drop_sc: got %b want 0", sc); end
    repeat (2 * PERIODO) @(posedge clk);
    #1;
    n_checks++; if (dv_n !== dv0) begin n_fail++; $display("FAIL drop_no_dv: got %0d pulses want 0", dv_n - dv0); end
    n_checks++; if (dato !== dato0) begin n_fail++; $display("FAIL drop_dato_hold: got %0d want %0d", dato, dato0); end
    n_checks++; if (muestra !== 8'd60) begin n_fail++; $display("FAIL drop_muestra_hold: got %0d want 60", muestra); end
    samples.delete();
    for (int i = 0; i < N; i++) samples.push_back(8'd8);
    enable = 1'b1;
    wait_dv(N * PERIODO + 100, got);
    n_checks++; if (got !== 1'b1 || dato !== 8'd8) begin n_fail++; $display("FAIL drop_resume: got %0d (dv %b) want 8", dato, got); end
  endtask

  task automatic test_reset_mid();
    bit ok, got;
    int v[N];
    restart();
    wait_sc(2 * PERIODO, ok);
    rst_n = 1'b0;
    #1;
    n_checks++; if (sc !== 1'b0 || dato_valido !== 1'b0 || error_to !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_ctl: got sc %b dv %b err %b want 0 0 0", sc, dato_valido, error_to);
    end
    n_checks++; if (dato !== 8'd0 || muestra !== 8'd0) begin
      n_fail++; $display("FAIL rst_mid_data: got dato %0d muestra %0d want 0 0", dato, muestra);
    end
    enable = 1'b0;
    repeat (3) @(posedge clk);
    for (int k = 0; k < 300 && busy; k++) @(posedge clk);
    #1;
    samples.delete();
    for (int i = 0; i < N; i++) begin
      v[i] = int'($urandom_range(0, 255));
      samples.push_back(8'(v[i]));
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    enable = 1'b1;
    wait_dv(N * PERIODO + 100, got);
    n_checks++; if (got !== 1'b1 || dato !== 8'(mean_of(v))) begin
      n_fail++; $display("FAIL rst_resume: got %0d (dv %b) want %0d", dato, got, mean_of(v));
    end
  endtask

  task automatic test_long_conv();
    bit got;
    int f0;
    int v[N];
    conv_delay = 70;
    restart();
    f0 = fed_n;
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < N; i++) begin
        v[i] = int'($urandom_range(0, 255));
        samples.push_back(8'(v[i]));
      end
      wait_dv(N * 120 + 100, got);
      n_checks++; if (got !== 1'b1 || dato !== 8'(mean_of(v))) begin
        n_fail++; $display("FAIL long_dato[%0d]: got %0d (dv %b) want %0d", g, dato, got, mean_of(v));
      end
      n_checks++; if (fed_n - f0 !== N * (g + 1)) begin
        n_fail++; $display("FAIL long_count[%0d]: got %0d samples want %0d", g, fed_n - f0, N * (g + 1));
      end
    end
    n_checks++; if (eoc_sc_max < 1 || eoc_sc_max > 7) begin
      n_fail++; $display("FAIL long_restart_gap: got %0d cycles want 1..7", eoc_sc_max);
    end
    conv_delay = 20;
  endtask

  initial begin
    test_reset();
    test_average();
    test_extremes();
    test_random();
    test_timeout();
    test_enable_drop();
    test_reset_mid();
    test_long_conv();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
